// File: rtl/pipe_control.sv
`timescale 1ns/1ps
// pipe_control
// Control and hazard unit for a classic five-stage in-order pipeline.
// It decodes the ID opcode into EX/MEM/WB control fields and carries them
// through the ID/EX (_p0), EX/MEM (_p1) and MEM/WB (_p2) registers together
// with the register addresses needed for hazard detection and forwarding.
//
// Ports
//   clk          rising-edge clock for all state
//   rst          synchronous active-high reset
//   opcode_id    opcode of the instruction in ID
//   rs_id/rt_id  source register addresses of the instruction in ID
//   rd_id        destination register address (R-format) in ID
//   zero_mem     ALU zero flag of the instruction in MEM
//   ex_ctrl      {RegDst, ALUOp[1:0], ALUSrc} from ID/EX
//   mem_ctrl     {Branch, MemRead, MemWrite} from EX/MEM
//   wb_ctrl      {RegWrite, MemtoReg} from MEM/WB
//   pcsrc        branch in MEM is taken this cycle
//   pc_write     PC load enable (low during a load-use stall)
//   ifid_write   IF/ID load enable (low during a load-use stall)
//   ifid_flush   clear IF/ID (taken branch)
//   fwd_a/fwd_b  EX operand forwarding: 10 = EX/MEM, 01 = MEM/WB, 00 = none
//   stall_cnt    saturating count of load-use stall cycles
//   flush_cnt    saturating count of taken-branch flush cycles
module pipe_control #(
  parameter int OPC_W = 6,
  parameter int RA_W  = 5,
  parameter int CNT_W = 16,
  parameter logic [OPC_W-1:0] OP_R   = 6'b111111,
  parameter logic [OPC_W-1:0] OP_I   = 6'b000011,
  parameter logic [OPC_W-1:0] OP_LW  = 6'b100011,
  parameter logic [OPC_W-1:0] OP_SW  = 6'b101011,
  parameter logic [OPC_W-1:0] OP_BEQ = 6'b000100
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [OPC_W-1:0] opcode_id,
  input  logic [RA_W-1:0]  rs_id,
  input  logic [RA_W-1:0]  rt_id,
  input  logic [RA_W-1:0]  rd_id,
  input  logic             zero_mem,
  output logic [3:0]       ex_ctrl,
  output logic [2:0]       mem_ctrl,
  output logic [1:0]       wb_ctrl,
  output logic             pcsrc,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  // Counter increment that holds at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Forwarding priority: the younger producer (EX/MEM) wins over MEM/WB;
  // register 0 is never forwarded.
  function automatic logic [1:0] fwd_sel(
    input logic [RA_W-1:0] src,
    input logic            wr_mem,
    input logic [RA_W-1:0] dest_mem,
    input logic            wr_wb,
    input logic [RA_W-1:0] dest_wb
  );
    if (wr_mem && (dest_mem != '0) && (dest_mem == src))
      return 2'b10;
    else if (wr_wb && (dest_wb != '0) && (dest_wb == src))
      return 2'b01;
    else
      return 2'b00;
  endfunction

  logic [3:0]      dec_ex;
  logic [2:0]      dec_mem;
  logic [1:0]      dec_wb;
  logic [RA_W-1:0] dest_id;

  logic [3:0]      ex_p0;
  logic [2:0]      mem_p0;
  logic [1:0]      wb_p0;
  logic [RA_W-1:0] rs_p0;
  logic [RA_W-1:0] rt_p0;
  logic [RA_W-1:0] dest_p0;

  logic [2:0]      mem_p1;
  logic [1:0]      wb_p1;
  logic [RA_W-1:0] dest_p1;

  logic [1:0]      wb_p2;
  logic [RA_W-1:0] dest_p2;

  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_q;

  logic load_use;
  logic stall;
  logic bubble_p0;

  // ---- ID: opcode decode ----
  always_comb begin
    dec_ex  = '0;
    dec_mem = '0;
    dec_wb  = '0;
    case (opcode_id)
      OP_R: begin
        dec_ex = 4'b1100;
        dec_wb = 2'b10;
      end
      OP_I: begin
        dec_ex = 4'b0111;
        dec_wb = 2'b10;
      end
      OP_LW: begin
        dec_ex  = 4'b0001;
        dec_mem = 3'b010;
        dec_wb  = 2'b11;
      end
      OP_SW: begin
        dec_ex  = 4'b0001;
        dec_mem = 3'b001;
      end
      OP_BEQ: begin
        dec_ex  = 4'b0010;
        dec_mem = 3'b100;
      end
      default: ;
    endcase
  end

  assign dest_id = dec_ex[3] ? rd_id : rt_id;

  // ---- Hazard and branch resolution ----
  assign pcsrc     = mem_p1[2] & zero_mem;
  assign load_use  = mem_p0[1] & ((rt_p0 == rs_id) | (rt_p0 == rt_id));
  assign stall     = load_use & ~pcsrc;
  assign bubble_p0 = stall | pcsrc;

  assign pc_write   = ~stall;
  assign ifid_write = ~stall;
  assign ifid_flush = pcsrc;

  // ---- EX: forwarding select ----
  assign fwd_a = fwd_sel(rs_p0, wb_p1[1], dest_p1, wb_p2[1], dest_p2);
  assign fwd_b = fwd_sel(rt_p0, wb_p1[1], dest_p1, wb_p2[1], dest_p2);

  // ---- Pipeline registers: ID/EX (_p0), EX/MEM (_p1), MEM/WB (_p2) ----
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_p0       <= '0;
      mem_p0      <= '0;
      wb_p0       <= '0;
      rs_p0       <= '0;
      rt_p0       <= '0;
      dest_p0     <= '0;
      mem_p1      <= '0;
      wb_p1       <= '0;
      dest_p1     <= '0;
      wb_p2       <= '0;
      dest_p2     <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      // ID -> EX: a stall or a flush turns this slot into a bubble
      ex_p0   <= bubble_p0 ? 4'b0000 : dec_ex;
      mem_p0  <= bubble_p0 ? 3'b000  : dec_mem;
      wb_p0   <= bubble_p0 ? 2'b00   : dec_wb;
      rs_p0   <= rs_id;
      rt_p0   <= rt_id;
      dest_p0 <= dest_id;

      // EX -> MEM: squashed on a taken branch, otherwise always advances
      mem_p1  <= pcsrc ? 3'b000 : mem_p0;
      wb_p1   <= pcsrc ? 2'b00  : wb_p0;
      dest_p1 <= dest_p0;

      // MEM -> WB: always advances
      wb_p2   <= wb_p1;
      dest_p2 <= dest_p1;

      if (stall)
        stall_cnt_q <= sat_inc(stall_cnt_q);
      if (pcsrc)
        flush_cnt_q <= sat_inc(flush_cnt_q);
    end
  end

  assign ex_ctrl   = ex_p0;
  assign mem_ctrl  = mem_p1;
  assign wb_ctrl   = wb_p2;
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule
